// File: rtl/i2s_axis_pkg.sv
// Purpose : shared state encoding, channel flag values and counter widths for the I2S-to-AXIS burst controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package i2s_axis_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_SEND      = 3'd3,
        ST_FILL      = 3'd4
    } state_t;

    // Value of the top bit of a FIFO word: which I2S channel it came from.
    localparam logic CHAN_LEFT  = 1'b0;
    localparam logic CHAN_RIGHT = 1'b1;

    localparam int BURST_CNT_W = 16;
    localparam int ERR_CNT_W   = 8;

endpackage

// File: rtl/i2s_axis_burst_ctrl_err.sv
// Purpose : optional 2FF synchroniser, rising-edge detect and 8-bit saturating event counter.
// Latency : 3 cycles from flag to count (SYNC_EN=1), 1 cycle when the synchroniser is bypassed.
// Backpressure: none; counts every detected rising edge until it saturates at 255.
// Ports   : clk, rst_n (async active-low), flag_in (level or pulse), count (saturating event count).
module err_sync_edge_cnt
    import i2s_axis_pkg::*;
#(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flag_in,
    output logic [ERR_CNT_W-1:0] count
);

    logic                 sync1_q, sync2_q, prev_q;
    logic                 lvl;
    logic                 rise;
    logic [ERR_CNT_W-1:0] count_q, count_d;

    // A synchronous source skips the synchroniser so its pulses are not delayed.
    assign lvl  = SYNC_EN ? sync2_q : flag_in;
    assign rise = lvl & ~prev_q;

    always_comb begin
        count_d = count_q;
        if (rise && (count_q != {ERR_CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            sync1_q <= flag_in;
            sync2_q <= sync1_q;
            prev_q  <= lvl;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/i2s_axis_burst_ctrl.sv
// Purpose : reads words from the I2S receive FIFO and emits them as fixed-length AXI4-Stream bursts with TLAST.
// Latency : RD_HOLD_CYCLES + RD_LATENCY + 1 cycles from read start to TVALID; one beat per FIFO read.
// Backpressure: holds one word under TREADY low; no new FIFO read is issued while TVALID is high.
// Ports   : M_AXIS_ACLK/M_AXIS_ARESETN clock and async active-low reset; enable, fifo_* read side of the FIFO;
//           M_AXIS_* stream master; busy, burst_count, overflow_count, underflow_count status.
// Option  : define I2S_AXIS_CHANNEL_ALIGN_EN to drop right-channel words at burst start (adds misalign_count).
module i2s_axis_burst_ctrl
    import i2s_axis_pkg::*;
#(
    parameter int DATA_WIDTH             = 32,
    parameter int NUMBER_OF_OUTPUT_WORDS = 8,
    parameter int RD_HOLD_CYCLES         = 3,
    parameter int RD_LATENCY             = 1
) (
    input  logic                    M_AXIS_ACLK,
    input  logic                    M_AXIS_ARESETN,
    input  logic                    enable,
    input  logic                    fifo_output_ready,
    input  logic [DATA_WIDTH-1:0]   fifo_rdata,
    input  logic                    fifo_buffer_full_error,
    input  logic                    fifo_buffer_empty_error,
    output logic                    fifo_read_enable,
    output logic                    M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                    M_AXIS_TLAST,
    input  logic                    M_AXIS_TREADY,
    output logic                    busy,
`ifdef I2S_AXIS_CHANNEL_ALIGN_EN
    output logic [ERR_CNT_W-1:0]    misalign_count,
`endif
    output logic [BURST_CNT_W-1:0]  burst_count,
    output logic [ERR_CNT_W-1:0]    overflow_count,
    output logic [ERR_CNT_W-1:0]    underflow_count
);

    localparam logic [7:0] LAST_IDX  = 8'(NUMBER_OF_OUTPUT_WORDS - 1);
    localparam logic [3:0] HOLD_LOAD = 4'(RD_HOLD_CYCLES - 1);
    localparam logic [3:0] LAT_LOAD  = 4'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

    state_t                 state_q, state_d;
    logic [3:0]             hold_cnt_q, hold_cnt_d;
    logic [3:0]             lat_cnt_q, lat_cnt_d;
    logic [7:0]             word_idx_q, word_idx_d;
    logic                   rd_en_q, rd_en_d;
    logic                   tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic                   tlast_q, tlast_d;
    logic                   busy_q, busy_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic                   do_capture;
    logic                   start_issue;
    logic                   misalign_pulse;

    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        lat_cnt_d      = lat_cnt_q;
        word_idx_d     = word_idx_q;
        rd_en_d        = rd_en_q;
        tvalid_d       = tvalid_q;
        tdata_d        = tdata_q;
        tlast_d        = tlast_q;
        burst_cnt_d    = burst_cnt_q;
        do_capture     = 1'b0;
        start_issue    = 1'b0;
        misalign_pulse = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && fifo_output_ready) begin
                    start_issue = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (hold_cnt_q == 4'd0) begin
                    rd_en_d = 1'b0;
                    // Zero latency: data is already valid as the strobe drops.
                    if (RD_LATENCY == 0) begin
                        do_capture = 1'b1;
                    end else begin
                        state_d   = ST_WAIT_DATA;
                        lat_cnt_d = LAT_LOAD;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            ST_WAIT_DATA: begin
                if (lat_cnt_q == 4'd0) begin
                    do_capture = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            ST_SEND: begin
                if (M_AXIS_TREADY) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (tlast_q) begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                        word_idx_d  = 8'd0;
                        state_d     = ST_IDLE;
                    end else begin
                        word_idx_d = word_idx_q + 8'd1;
                        if (fifo_output_ready) begin
                            start_issue = 1'b1;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                end
            end
            ST_FILL: begin
                if (fifo_output_ready) begin
                    start_issue = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_capture) begin
`ifdef I2S_AXIS_CHANNEL_ALIGN_EN
            // A burst must open on a left sample; a leading right word is dropped and re-read.
            if ((word_idx_q == 8'd0) && (fifo_rdata[DATA_WIDTH-1] == CHAN_RIGHT)) begin
                misalign_pulse = 1'b1;
                if (fifo_output_ready) begin
                    start_issue = 1'b1;
                end else begin
                    state_d = ST_FILL;
                end
            end else
`endif
            begin
                tdata_d  = fifo_rdata;
                tlast_d  = (word_idx_q == LAST_IDX);
                tvalid_d = 1'b1;
                state_d  = ST_SEND;
            end
        end

        if (start_issue) begin
            state_d    = ST_ISSUE;
            rd_en_d    = 1'b1;
            hold_cnt_d = HOLD_LOAD;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= 4'd0;
            lat_cnt_q   <= 4'd0;
            word_idx_q  <= 8'd0;
            rd_en_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            word_idx_q  <= word_idx_d;
            rd_en_q     <= rd_en_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign fifo_read_enable = rd_en_q;
    assign M_AXIS_TVALID    = tvalid_q;
    assign M_AXIS_TDATA     = tdata_q;
    assign M_AXIS_TLAST     = tlast_q;
    assign M_AXIS_TSTRB     = {(DATA_WIDTH/8){1'b1}};
    assign busy             = busy_q;
    assign burst_count      = burst_cnt_q;

    err_sync_edge_cnt #(.SYNC_EN(1'b1)) u_ovf_cnt (
        .clk     (M_AXIS_ACLK),
        .rst_n   (M_AXIS_ARESETN),
        .flag_in (fifo_buffer_full_error),
        .count   (overflow_count)
    );

    err_sync_edge_cnt #(.SYNC_EN(1'b1)) u_udf_cnt (
        .clk     (M_AXIS_ACLK),
        .rst_n   (M_AXIS_ARESETN),
        .flag_in (fifo_buffer_empty_error),
        .count   (underflow_count)
    );

`ifdef I2S_AXIS_CHANNEL_ALIGN_EN
    err_sync_edge_cnt #(.SYNC_EN(1'b0)) u_mis_cnt (
        .clk     (M_AXIS_ACLK),
        .rst_n   (M_AXIS_ARESETN),
        .flag_in (misalign_pulse),
        .count   (misalign_count)
    );
`else
    logic unused_misalign;
    assign unused_misalign = misalign_pulse;
`endif

endmodule

// File: tb/tb_i2s_axis_burst_ctrl.sv
module tb_i2s_axis_burst_ctrl;

    localparam int DW   = 32;
    localparam int NW   = 8;
    localparam int HOLD = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_output_ready = 1'b0;
    logic [DW-1:0] fifo_rdata = '0;
    logic          full_err = 1'b0;
    logic          empty_err = 1'b0;
    logic          rd_en;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic [3:0]    tstrb;
    logic          tlast;
    logic          tready = 1'b1;
    logic          busy;
    logic [15:0]   burst_count;
    logic [7:0]    overflow_count;
    logic [7:0]    underflow_count;
`ifdef I2S_AXIS_CHANNEL_ALIGN_EN
    logic [7:0]    misalign_count;
`endif

    always #5 clk = ~clk;

    i2s_axis_burst_ctrl dut (
        .M_AXIS_ACLK             (clk),
        .M_AXIS_ARESETN          (rst_n),
        .enable                  (enable),
        .fifo_output_ready       (fifo_output_ready),
        .fifo_rdata              (fifo_rdata),
        .fifo_buffer_full_error  (full_err),
        .fifo_buffer_empty_error (empty_err),
        .fifo_read_enable        (rd_en),
        .M_AXIS_TVALID           (tvalid),
        .M_AXIS_TDATA            (tdata),
        .M_AXIS_TSTRB            (tstrb),
        .M_AXIS_TLAST            (tlast),
        .M_AXIS_TREADY           (tready),
        .busy                    (busy),
`ifdef I2S_AXIS_CHANNEL_ALIGN_EN
        .misalign_count          (misalign_count),
`endif
        .burst_count             (burst_count),
        .overflow_count          (overflow_count),
        .underflow_count         (underflow_count)
    );

    int total = 0;
    int bad   = 0;

    // FIFO model state
    logic [DW-1:0] q[$];
    logic          prev_rd = 1'b0;
    int            rd_w = 0;
    int            viol = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge. Models the FIFO:
    // a word is popped when the read strobe falls and is valid one cycle later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_en) rd_w++;
        if (prev_rd && !rd_en) begin
            chk("strobe_width", 32'(rd_w), 32'(HOLD));
            rd_w = 0;
            if (q.size() != 0) fifo_rdata = q.pop_front();
        end
        if (rd_en && tvalid) viol++;
        prev_rd = rd_en;
        fifo_output_ready = (q.size() != 0);
    endtask

    typedef struct {
        int  n_pre;       // words in the FIFO at start
        int  n_total;     // words for the burst
        int  stall_beat;  // 1-based beat held off by TREADY (0 = none)
        int  stall_cyc;
        int  drop_en_at;  // enable falls after this many beats (0 = never)
        int  extra;       // words left in the FIFO after the burst
        bit  lead_right;  // a right-channel word precedes the burst
        int  exp_beats;
        int  exp_bursts;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{8, 8, 0, 0,  0, 0, 1'b0, 8, 1});  // basic
        vecs.push_back('{8, 8, 3, 10, 0, 0, 1'b0, 8, 2});  // backpressure
        vecs.push_back('{5, 8, 0, 0,  0, 0, 1'b0, 8, 3});  // starvation
        vecs.push_back('{8, 8, 0, 0,  2, 1, 1'b0, 8, 4});  // enable drop
`ifdef I2S_AXIS_CHANNEL_ALIGN_EN
        vecs.push_back('{8, 8, 0, 0,  0, 0, 1'b1, 8, 5});  // misaligned start
`endif

        // Reset state
        repeat (3) tick();
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tlast", 32'(tlast), 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_bursts", 32'(burst_count), 0);
        chk("tstrb", 32'(tstrb), 32'hF);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            logic [DW-1:0] base;
            int  pushed, beats, stall_left, starve, rd_hi;
            bit  done;
            v = vecs[k];
            base = 32'((k + 1) << 8);
            q.delete();
            if (v.lead_right) q.push_back(32'h8000_0011);
            for (int i = 0; i < v.n_pre; i++) q.push_back(base + 32'(i + 1));
            for (int i = 0; i < v.extra; i++) q.push_back(32'hEEEE_0000 + 32'(i));
            pushed = v.n_pre;
            fifo_output_ready = 1'b1;
            enable = 1'b1;
            beats = 0;
            stall_left = v.stall_cyc;
            starve = 0;
            done = 1'b0;
            viol = 0;
            for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
                if (v.drop_en_at != 0 && beats >= v.drop_en_at) enable = 1'b0;
                tready = 1'b1;
                if (tvalid && (beats + 1 == v.stall_beat) && stall_left > 0) begin
                    tready = 1'b0;
                    stall_left--;
                end
                if (tvalid && tready) begin
                    chk($sformatf("v%0d_tdata%0d", k, beats), tdata, base + 32'(beats + 1));
                    chk($sformatf("v%0d_tlast%0d", k, beats), 32'(tlast), 32'(beats == NW - 1));
                    beats++;
                    if (tlast) done = 1'b1;
                end
                if (pushed < v.n_total && q.size() == 0) begin
                    starve++;
                    if (starve == 20) begin
                        chk($sformatf("v%0d_fill_busy", k), 32'(busy), 1);
                        chk($sformatf("v%0d_fill_tvalid", k), 32'(tvalid), 0);
                        for (int i = pushed; i < v.n_total; i++) q.push_back(base + 32'(i + 1));
                        pushed = v.n_total;
                    end
                end
                tick();
            end
            if (!done) begin
                bad++;
                total++;
                $display("FAIL v%0d_timeout beats=%0d expected=%0d", k, beats, v.exp_beats);
            end
            chk($sformatf("v%0d_beats", k), 32'(beats), 32'(v.exp_beats));
            tready = 1'b1;
            rd_hi = 0;
            repeat (30) begin
                tick();
                if (rd_en) rd_hi++;
            end
            chk($sformatf("v%0d_idle_reads", k), 32'(rd_hi), 0);
            chk($sformatf("v%0d_busy_after", k), 32'(busy), 0);
            chk($sformatf("v%0d_bursts", k), 32'(burst_count), 32'(v.exp_bursts));
            chk($sformatf("v%0d_rd_during_valid", k), 32'(viol), 0);
`ifdef I2S_AXIS_CHANNEL_ALIGN_EN
            if (v.lead_right) chk("misalign_count", 32'(misalign_count), 1);
`endif
            q.delete();
            fifo_output_ready = 1'b0;
            enable = 1'b0;
        end

        // Error counters: saturation on overflow, plain count on underflow
        for (int i = 0; i < 300; i++) begin
            full_err = 1'b1;
            repeat (2) tick();
            full_err = 1'b0;
            repeat (2) tick();
        end
        for (int i = 0; i < 3; i++) begin
            empty_err = 1'b1;
            repeat (3) tick();
            empty_err = 1'b0;
            repeat (3) tick();
        end
        repeat (4) tick();
        chk("overflow_sat", 32'(overflow_count), 255);
        chk("underflow_cnt", 32'(underflow_count), 3);
        chk("err_no_fsm_effect", 32'(busy), 0);

        // Reset while a beat is stalled in SEND
        begin
            bit seen;
            seen = 1'b0;
            q.push_back(32'h0000_0055);
            fifo_output_ready = 1'b1;
            enable = 1'b1;
            tready = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                tick();
                if (tvalid) seen = 1'b1;
            end
            chk("send_reached", 32'(seen), 1);
            chk("send_tdata", tdata, 32'h55);
            #2;
            rst_n = 1'b0;
            #1;
            chk("arst_tvalid", 32'(tvalid), 0);
            chk("arst_tdata", tdata, 0);
            chk("arst_busy", 32'(busy), 0);
            chk("arst_tlast", 32'(tlast), 0);
            chk("arst_rd_en", 32'(rd_en), 0);
            chk("arst_bursts", 32'(burst_count), 0);
            chk("arst_overflow", 32'(overflow_count), 0);
            chk("arst_underflow", 32'(underflow_count), 0);
            enable = 1'b0;
            tready = 1'b1;
            q.delete();
            fifo_output_ready = 1'b0;
            prev_rd = 1'b0;
            rd_w = 0;
            repeat (2) tick();
            rst_n = 1'b1;
            repeat (5) tick();
            chk("post_rst_idle", 32'(busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
